// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b shared types: control word, pipeline stage record, bubble constant
package lc3b_types;

    localparam int CONTROL_WIDTH = 33;
    localparam int PIPE_STAGES   = 4;

    typedef logic [CONTROL_WIDTH-1:0] lc3b_control;

    typedef struct packed {
        logic        valid;
        lc3b_control ctrl;
    } lc3b_ctrl_stage;

    localparam lc3b_control BUBBLE_CTRL = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// rtl/ctrl_stage_reg.sv - one control-word pipeline register with flush/hold/bubble/load priority
module ctrl_stage_reg
    import lc3b_types::*;
#(
    parameter int               WIDTH       = CONTROL_WIDTH,
    parameter logic [WIDTH-1:0] BUBBLE_WORD = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             hold,
    input  logic             up_hold,
    input  logic [WIDTH-1:0] up_ctrl,
    input  logic             up_valid,
    output logic [WIDTH-1:0] ctrl_q,
    output logic             valid_q
);

    logic [WIDTH-1:0] ctrl_d;
    logic             valid_d;

    // Next-state mux: flush beats hold; a frozen upstream feeds a bubble instead of its word.
    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        if (flush) begin
            ctrl_d  = BUBBLE_WORD;
            valid_d = 1'b0;
        end else if (hold) begin
            ctrl_d  = ctrl_q;
            valid_d = valid_q;
        end else if (up_hold) begin
            ctrl_d  = BUBBLE_WORD;
            valid_d = 1'b0;
        end else begin
            ctrl_d  = up_ctrl;
            valid_d = up_valid;
        end
    end

    // Stage register, cleared to a bubble by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q  <= BUBBLE_WORD;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/ctrl_pipe_regs.sv
// rtl/ctrl_pipe_regs.sv - stallable/flushable control-word pipeline with retire and stall counters
module ctrl_pipe_regs
    import lc3b_types::*;
#(
    parameter int               WIDTH       = CONTROL_WIDTH,
    parameter int               STAGES      = PIPE_STAGES,
    parameter int               CNT_WIDTH   = 16,
    parameter logic [WIDTH-1:0] BUBBLE_WORD = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        ctrl_in,
    input  logic                    valid_in,
    input  logic [STAGES-1:0]       stall,
    input  logic [STAGES-1:0]       flush,
    output logic [STAGES*WIDTH-1:0] ctrl_out,
    output logic [STAGES-1:0]       valid_out,
    output logic [STAGES-1:0]       hold_out,
    input  logic                    cnt_clr,
    output logic [CNT_WIDTH-1:0]    retire_cnt,
    output logic [CNT_WIDTH-1:0]    stall_cnt
);

    logic [STAGES-1:0]    hold;
    logic                 retire_inc;
    logic                 stall_inc;
    logic [CNT_WIDTH-1:0] retire_cnt_d;
    logic [CNT_WIDTH-1:0] retire_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    // Hold ripples upstream from stall only, so a flushed stage still freezes those behind it.
    for (genvar k = 0; k < STAGES; k++) begin : g_hold
        if (k == STAGES - 1) begin : g_last
            assign hold[k] = stall[k];
        end else begin : g_mid
            assign hold[k] = stall[k] | hold[k+1];
        end
    end

    assign hold_out = hold;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] up_ctrl;
        logic             up_valid;
        logic             up_hold;

        // Stage 0 has no upstream register, so it never takes a bubble.
        if (k == 0) begin : g_first
            assign up_ctrl  = ctrl_in;
            assign up_valid = valid_in;
            assign up_hold  = 1'b0;
        end else begin : g_next
            assign up_ctrl  = ctrl_out[(k-1)*WIDTH +: WIDTH];
            assign up_valid = valid_out[k-1];
            assign up_hold  = hold[k-1];
        end

        ctrl_stage_reg #(
            .WIDTH       (WIDTH),
            .BUBBLE_WORD (BUBBLE_WORD)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush[k]),
            .hold     (hold[k]),
            .up_hold  (up_hold),
            .up_ctrl  (up_ctrl),
            .up_valid (up_valid),
            .ctrl_q   (ctrl_out[k*WIDTH +: WIDTH]),
            .valid_q  (valid_out[k])
        );
    end

    assign retire_inc = valid_out[STAGES-1] & ~hold[STAGES-1] & ~flush[STAGES-1];
    assign stall_inc  = hold[0];

    // Counter next state: clear wins over increment, both wrap freely.
    always_comb begin
        retire_cnt_d = retire_cnt_q + CNT_WIDTH'(retire_inc);
        stall_cnt_d  = stall_cnt_q + CNT_WIDTH'(stall_inc);
        if (cnt_clr) begin
            retire_cnt_d = '0;
            stall_cnt_d  = '0;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// tb/tb_ctrl_pipe_regs.sv - scoreboard bench for ctrl_pipe_regs (4-stage and 1-stage builds)
module tb_ctrl_pipe_regs;

    localparam int W  = 33;
    localparam int S  = 4;
    localparam int CW = 16;
    localparam int W1 = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [W-1:0]    ctrl_in = '0;
    logic            valid_in = 1'b0;
    logic [S-1:0]    stall = '0;
    logic [S-1:0]    flush = '0;
    logic [S*W-1:0]  ctrl_out;
    logic [S-1:0]    valid_out;
    logic [S-1:0]    hold_out;
    logic            cnt_clr = 1'b0;
    logic [CW-1:0]   retire_cnt;
    logic [CW-1:0]   stall_cnt;

    logic [W1-1:0]   r1_ctrl_in = '0;
    logic            r1_valid_in = 1'b0;
    logic [0:0]      r1_stall = '0;
    logic [0:0]      r1_flush = '0;
    logic [W1-1:0]   r1_ctrl_out;
    logic [0:0]      r1_valid_out;
    logic [0:0]      r1_hold_out;
    logic            r1_cnt_clr = 1'b0;
    logic [CW-1:0]   r1_retire_cnt;
    logic [CW-1:0]   r1_stall_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit sb_en = 1'b0;
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    ctrl_pipe_regs #(.WIDTH(W), .STAGES(S), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in),
        .stall(stall), .flush(flush), .ctrl_out(ctrl_out), .valid_out(valid_out),
        .hold_out(hold_out), .cnt_clr(cnt_clr), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
    );

    ctrl_pipe_regs #(.WIDTH(W1), .STAGES(1), .CNT_WIDTH(CW)) dut1 (
        .clk(clk), .reset(reset), .ctrl_in(r1_ctrl_in), .valid_in(r1_valid_in),
        .stall(r1_stall), .flush(r1_flush), .ctrl_out(r1_ctrl_out), .valid_out(r1_valid_out),
        .hold_out(r1_hold_out), .cnt_clr(r1_cnt_clr), .retire_cnt(r1_retire_cnt), .stall_cnt(r1_stall_cnt)
    );

    // Retirement monitor: a valid last-stage word about to leave must be the oldest expected word.
    always @(negedge clk) begin
        if (sb_en && !reset && valid_out[S-1] && !hold_out[S-1] && !flush[S-1]) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL retire_order: got %h, expected nothing (scoreboard empty)", ctrl_out[(S-1)*W +: W]);
            end else begin
                logic [W-1:0] exp_w;
                exp_w = sb.pop_front();
                if (ctrl_out[(S-1)*W +: W] !== exp_w)
                    $display("FAIL retire_order: got %h, expected %h", ctrl_out[(S-1)*W +: W], exp_w);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic cycle();
        if (valid_in && stall == '0 && !flush[0])
            sb.push_back(ctrl_in);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sb_en = 1'b0;
        ctrl_in = '0; valid_in = 1'b0; stall = '0; flush = '0; cnt_clr = 1'b0;
        r1_ctrl_in = '0; r1_valid_in = 1'b0; r1_stall = '0; r1_flush = '0; r1_cnt_clr = 1'b0;
        sb.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain_and_check(input string name);
        valid_in = 1'b0; stall = '0; flush = '0;
        repeat (6) cycle();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL %s_drain: %0d words left, expected 0", name, sb.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = '0;
        #1;
        total_cnt++;
        if (valid_out !== 4'b0000 || ctrl_out !== '0) $display("FAIL reset_state: valid=%b ctrl=%h, expected 0/0", valid_out, ctrl_out);
        else pass_cnt++;
        total_cnt++;
        if (retire_cnt !== 16'd0 || stall_cnt !== 16'd0) $display("FAIL reset_cnt: retire=%0d stall=%0d, expected 0/0", retire_cnt, stall_cnt);
        else pass_cnt++;
        total_cnt++;
        if (hold_out !== 4'b0000) $display("FAIL reset_hold: got %b, expected 0000", hold_out);
        else pass_cnt++;
        stall = 4'b0100;
        #1;
        total_cnt++;
        if (hold_out !== 4'b0111) $display("FAIL hold_chain_2: got %b, expected 0111", hold_out);
        else pass_cnt++;
        stall = 4'b1000;
        #1;
        total_cnt++;
        if (hold_out !== 4'b1111) $display("FAIL hold_chain_3: got %b, expected 1111", hold_out);
        else pass_cnt++;
        stall = '0;
        do_reset();
    endtask

    task automatic test_stream();
        do_reset();
        sb_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ctrl_in = W'(i); valid_in = 1'b1;
            cycle();
            if (i == 3) begin
                total_cnt++;
                if (valid_out[3] !== 1'b0 || ctrl_out[2*W +: W] !== W'(1))
                    $display("FAIL latency_edge3: v3=%b s2=%h, expected 0/1", valid_out[3], ctrl_out[2*W +: W]);
                else pass_cnt++;
            end
        end
        valid_in = 1'b0; ctrl_in = '0;
        total_cnt++;
        if (valid_out[3] !== 1'b1 || ctrl_out[3*W +: W] !== W'(1))
            $display("FAIL latency_edge4: v3=%b s3=%h, expected 1/1", valid_out[3], ctrl_out[3*W +: W]);
        else pass_cnt++;
        repeat (5) cycle();
        total_cnt++;
        if (retire_cnt !== 16'd4) $display("FAIL stream_retire: got %0d, expected 4", retire_cnt);
        else pass_cnt++;
        drain_and_check("stream");
    endtask

    task automatic test_stall();
        logic [3*W-1:0] snap;
        logic [2:0]     vsnap;
        do_reset();
        sb_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ctrl_in = W'(32'h100 + i); valid_in = 1'b1;
            cycle();
        end
        ctrl_in = W'(32'h106);
        stall = 4'b0100;
        #1;
        total_cnt++;
        if (hold_out !== 4'b0111) $display("FAIL stall_hold: got %b, expected 0111", hold_out);
        else pass_cnt++;
        snap = ctrl_out[3*W-1:0];
        vsnap = valid_out[2:0];
        for (int c = 0; c < 2; c++) begin
            cycle();
            total_cnt++;
            if (ctrl_out[3*W-1:0] !== snap || valid_out[2:0] !== vsnap || valid_out[3] !== 1'b0 || ctrl_out[3*W +: W] !== '0)
                $display("FAIL stall_freeze: cyc %0d v=%b s3=%h, expected frozen 0-2 and bubble in 3", c, valid_out, ctrl_out[3*W +: W]);
            else pass_cnt++;
        end
        total_cnt++;
        if (stall_cnt !== 16'd2) $display("FAIL stall_cnt: got %0d, expected 2", stall_cnt);
        else pass_cnt++;
        stall = '0;
        for (int i = 6; i < 10; i++) begin
            ctrl_in = W'(32'h100 + i);
            cycle();
        end
        drain_and_check("stall");
        total_cnt++;
        if (retire_cnt !== 16'd10) $display("FAIL stall_retire: got %0d, expected 10", retire_cnt);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        logic [W-1:0] dropped;
        do_reset();
        sb_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ctrl_in = W'(32'h200 + i); valid_in = 1'b1;
            cycle();
        end
        ctrl_in = W'(32'h204);
        flush = 4'b0011; stall = 4'b0010;
        dropped = sb.pop_back();
        dropped = sb.pop_back();
        #1;
        total_cnt++;
        if (hold_out !== 4'b0011) $display("FAIL flush_hold: got %b, expected 0011", hold_out);
        else pass_cnt++;
        cycle();
        flush = '0; stall = '0;
        total_cnt++;
        if (valid_out[2:0] !== 3'b000 || ctrl_out[3*W-1:0] !== '0)
            $display("FAIL flush_bubbles: v=%b s0-2=%h, expected 000 and zero words", valid_out, ctrl_out[3*W-1:0]);
        else pass_cnt++;
        total_cnt++;
        if (valid_out[3] !== 1'b1 || ctrl_out[3*W +: W] !== W'(32'h201))
            $display("FAIL flush_advance: v3=%b s3=%h, expected 1/201", valid_out[3], ctrl_out[3*W +: W]);
        else pass_cnt++;
        drain_and_check("flush");
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ctrl_in = W'(32'h300 + i); valid_in = 1'b1;
            cycle();
        end
        stall = 4'b1111;
        cycle();
        cycle();
        #3;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (valid_out !== 4'b0000 || ctrl_out !== '0 || stall_cnt !== 16'd0 || retire_cnt !== 16'd0)
            $display("FAIL async_reset: v=%b stall_cnt=%0d retire=%0d, expected all 0", valid_out, stall_cnt, retire_cnt);
        else pass_cnt++;
        total_cnt++;
        if (hold_out !== 4'b1111) $display("FAIL async_reset_hold: got %b, expected 1111", hold_out);
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_wrap();
        do_reset();
        stall = 4'b0001;
        repeat (65535) cycle();
        total_cnt++;
        if (stall_cnt !== 16'hFFFF) $display("FAIL wrap_full: got %h, expected ffff", stall_cnt);
        else pass_cnt++;
        cycle();
        total_cnt++;
        if (stall_cnt !== 16'h0000) $display("FAIL wrap_zero: got %h, expected 0000", stall_cnt);
        else pass_cnt++;
        cycle();
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        total_cnt++;
        if (stall_cnt !== 16'h0000) $display("FAIL cnt_clr: got %h, expected 0000", stall_cnt);
        else pass_cnt++;
        stall = '0;
    endtask

    task automatic test_single_stage();
        do_reset();
        r1_ctrl_in = 8'hA5; r1_valid_in = 1'b1;
        cycle();
        total_cnt++;
        if (r1_ctrl_out !== 8'hA5 || r1_valid_out !== 1'b1) $display("FAIL s1_load: got %h/%b, expected a5/1", r1_ctrl_out, r1_valid_out);
        else pass_cnt++;
        r1_flush = 1'b1; r1_stall = 1'b1;
        #1;
        total_cnt++;
        if (r1_hold_out !== 1'b1) $display("FAIL s1_hold: got %b, expected 1", r1_hold_out);
        else pass_cnt++;
        cycle();
        r1_flush = 1'b0; r1_stall = 1'b0;
        total_cnt++;
        if (r1_valid_out !== 1'b0 || r1_ctrl_out !== 8'h00 || r1_retire_cnt !== 16'd0)
            $display("FAIL s1_flush: got %h/%b retire=%0d, expected 00/0/0", r1_ctrl_out, r1_valid_out, r1_retire_cnt);
        else pass_cnt++;
        r1_ctrl_in = 8'h77; r1_valid_in = 1'b0;
        cycle();
        total_cnt++;
        if (r1_ctrl_out !== 8'h77 || r1_valid_out !== 1'b0) $display("FAIL s1_invalid_pass: got %h/%b, expected 77/0", r1_ctrl_out, r1_valid_out);
        else pass_cnt++;
        r1_ctrl_in = 8'h3C; r1_valid_in = 1'b1;
        cycle();
        r1_valid_in = 1'b0;
        cycle();
        total_cnt++;
        if (r1_retire_cnt !== 16'd1) $display("FAIL s1_retire: got %0d, expected 1", r1_retire_cnt);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n_push;
        do_reset();
        sb_en = 1'b1;
        n_push = 0;
        for (int i = 0; i < 40; i++) begin
            ctrl_in = {1'($urandom_range(1)), 32'($urandom)};
            valid_in = 1'($urandom_range(3) != 0);
            stall = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 4'b0010 : 4'b0100) : 4'b0000;
            if (valid_in && stall == '0) n_push++;
            cycle();
        end
        drain_and_check("b2b");
        total_cnt++;
        if (retire_cnt !== CW'(n_push)) $display("FAIL b2b_retire: got %0d, expected %0d", retire_cnt, n_push);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_async_reset();
        test_single_stage();
        test_back_to_back();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
